// File: rtl/sdith_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
//   clog2      : ceiling log2 for parameter derivation.
//   cid_width  : client-id width for a given client count (never below 1).
//   ERR_*      : bit positions inside the sticky o_err vector.
package sdith_arb_pkg;

  localparam int unsigned ERR_OVERRUN  = 0;
  localparam int unsigned ERR_SPURIOUS = 1;
  localparam int unsigned ERR_W        = 2;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned cid_width(input int unsigned n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// Synchronous FIFO of client ids, used to route in-order multiplier results
// back to the client that issued them.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write an id (caller guarantees not full unless popping)
//   i_pop, o_data  : remove head id; o_data is the current head
//   o_full, o_empty: occupancy flags
// Push and pop on the same edge are legal, including at full.
// DEPTH must be a power of two and at least 2.
module arb_tag_fifo
  import sdith_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;

  always_comb begin
    wptr_d = wptr_q + (AW + 1)'(i_push);
    rptr_d = rptr_q + (AW + 1)'(i_pop);
  end

  assign o_data  = mem_q[rptr_q[AW-1:0]];
  assign o_empty = (wptr_q == rptr_q);
  assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      // At full with a pop, this overwrites the head slot being read out.
      if (i_push) mem_q[wptr_q[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/gf32_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined, in-order, fixed-latency field
// multiplier among N_CLIENTS requesters.
//   i_start/i_x/i_y : per-client request pulse and packed operands
//   o_busy          : client has a buffered, not yet issued request
//   o_done/o_o      : per-client result strobe and result value
//   o_mul_*/i_mul_* : shared multiplier issue and return interface
//   o_err           : sticky [ERR_OVERRUN] client overrun, [ERR_SPURIOUS] stray i_mul_done
module gf32_mul_arbiter
  import sdith_arb_pkg::*;
#(
  parameter int unsigned N_CLIENTS = 2,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_OUT   = 4,
  parameter int unsigned CID_W     = cid_width(N_CLIENTS)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N_CLIENTS-1:0]       i_start,
  input  logic [N_CLIENTS*WIDTH-1:0] i_x,
  input  logic [N_CLIENTS*WIDTH-1:0] i_y,
  output logic [N_CLIENTS-1:0]       o_busy,
  output logic [N_CLIENTS-1:0]       o_done,
  output logic [WIDTH-1:0]           o_o,
  output logic                       o_mul_start,
  output logic [WIDTH-1:0]           o_mul_x,
  output logic [WIDTH-1:0]           o_mul_y,
  input  logic [WIDTH-1:0]           i_mul_o,
  input  logic                       i_mul_done,
  output logic [ERR_W-1:0]           o_err
);

  logic [N_CLIENTS-1:0] pending_q, pending_d;
  logic [WIDTH-1:0]     op_x_q [N_CLIENTS];
  logic [WIDTH-1:0]     op_x_d [N_CLIENTS];
  logic [WIDTH-1:0]     op_y_q [N_CLIENTS];
  logic [WIDTH-1:0]     op_y_d [N_CLIENTS];
  logic [CID_W-1:0]     last_grant_q, last_grant_d;
  logic                 mul_start_q, mul_start_d;
  logic [WIDTH-1:0]     mul_x_q, mul_x_d;
  logic [WIDTH-1:0]     mul_y_q, mul_y_d;
  logic [N_CLIENTS-1:0] done_q, done_d;
  logic [WIDTH-1:0]     o_q, o_d;
  logic [ERR_W-1:0]     err_q, err_d;

  logic                 grant_vld;
  logic [CID_W-1:0]     grant_id;
  logic                 issue;
  logic [N_CLIENTS-1:0] grant_oh;
  logic [N_CLIENTS-1:0] accept;
  logic                 pop;
  logic                 fifo_full, fifo_empty;
  logic [CID_W-1:0]     fifo_head;

  // Round-robin: first pending client at or after last_grant+1, wrapping.
  always_comb begin
    int unsigned cand;
    logic [CID_W-1:0] cand_id;
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = 0;
    cand_id   = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      cand = i + 32'(last_grant_q) + 1;
      if (cand >= N_CLIENTS) cand = cand - N_CLIENTS;
      cand_id = CID_W'(cand);
      if (!grant_vld && pending_q[cand_id]) begin
        grant_vld = 1'b1;
        grant_id  = cand_id;
      end
    end
  end

  assign pop = i_mul_done && !fifo_empty;
  // A same-edge pop frees a slot, so a full FIFO does not block issue then.
  assign issue = grant_vld && (!fifo_full || pop);

  always_comb begin
    grant_oh = '0;
    if (issue) grant_oh[grant_id] = 1'b1;
  end

  // A client being issued this edge may refill its buffer on the same edge.
  assign accept = i_start & (~pending_q | grant_oh);

  always_comb begin
    pending_d    = (pending_q & ~grant_oh) | accept;
    last_grant_d = last_grant_q;
    mul_start_d  = issue;
    mul_x_d      = mul_x_q;
    mul_y_d      = mul_y_q;
    done_d       = '0;
    o_d          = o_q;
    err_d        = err_q;
    for (int unsigned c = 0; c < N_CLIENTS; c++) begin
      op_x_d[c] = op_x_q[c];
      op_y_d[c] = op_y_q[c];
      if (accept[c]) begin
        op_x_d[c] = i_x[WIDTH*c +: WIDTH];
        op_y_d[c] = i_y[WIDTH*c +: WIDTH];
      end
    end
    if (issue) begin
      mul_x_d      = op_x_q[grant_id];
      mul_y_d      = op_y_q[grant_id];
      last_grant_d = grant_id;
    end
    if (pop) begin
      done_d[fifo_head] = 1'b1;
      o_d               = i_mul_o;
    end
    if (|(i_start & pending_q & ~grant_oh)) err_d[ERR_OVERRUN] = 1'b1;
    if (i_mul_done && fifo_empty) err_d[ERR_SPURIOUS] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_q    <= '0;
      last_grant_q <= CID_W'(N_CLIENTS - 1);
      mul_start_q  <= 1'b0;
      mul_x_q      <= '0;
      mul_y_q      <= '0;
      done_q       <= '0;
      o_q          <= '0;
      err_q        <= '0;
      for (int unsigned c = 0; c < N_CLIENTS; c++) begin
        op_x_q[c] <= '0;
        op_y_q[c] <= '0;
      end
    end else begin
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      mul_start_q  <= mul_start_d;
      mul_x_q      <= mul_x_d;
      mul_y_q      <= mul_y_d;
      done_q       <= done_d;
      o_q          <= o_d;
      err_q        <= err_d;
      for (int unsigned c = 0; c < N_CLIENTS; c++) begin
        op_x_q[c] <= op_x_d[c];
        op_y_q[c] <= op_y_d[c];
      end
    end
  end

  arb_tag_fifo #(
    .DEPTH (MAX_OUT),
    .W     (CID_W)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (issue),
    .i_data  (grant_id),
    .i_pop   (pop),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_busy      = pending_q;
  assign o_done      = done_q;
  assign o_o         = o_q;
  assign o_mul_start = mul_start_q;
  assign o_mul_x     = mul_x_q;
  assign o_mul_y     = mul_y_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_gf32_mul_arbiter.sv
module tb_gf32_mul_arbiter;
  localparam int unsigned NC = 3;
  localparam int unsigned W  = 32;
  localparam int unsigned MO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NC-1:0] start = '0;
  logic [NC*W-1:0] x = '0, y = '0;
  logic [NC-1:0] busy, done;
  logic [W-1:0]  o_o, mul_x, mul_y, mul_o;
  logic          mul_start, mul_done;
  logic [1:0]    err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gf32_mul_arbiter #(
    .N_CLIENTS (NC),
    .WIDTH     (W),
    .MAX_OUT   (MO)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_x         (x),
    .i_y         (y),
    .o_busy      (busy),
    .o_done      (done),
    .o_o         (o_o),
    .o_mul_start (mul_start),
    .o_mul_x     (mul_x),
    .o_mul_y     (mul_y),
    .i_mul_o     (mul_o),
    .i_mul_done  (mul_done),
    .o_err       (err)
  );

  // Model multiplier: in-order, latency lat_m1+1, product = x*y mod 2^32.
  logic [3:0]   lat_m1 = 4'd2;
  logic         spur = 1'b0;
  logic [W-1:0] spur_val = '0;
  logic [15:0]  sr_v;
  logic [W-1:0] sr_o [16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_v <= '0;
      for (int i = 0; i < 16; i++) sr_o[i] <= '0;
    end else begin
      sr_v    <= {sr_v[14:0], mul_start};
      sr_o[0] <= mul_x * mul_y;
      for (int i = 1; i < 16; i++) sr_o[i] <= sr_o[i-1];
    end
  end

  assign mul_done = sr_v[lat_m1] | spur;
  assign mul_o    = spur ? spur_val : sr_o[lat_m1];

  // Event recorder on the opposite edge.
  typedef struct {
    int            cyc;
    logic [NC-1:0] who;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
  } ev_t;
  ev_t iss_q[$];
  ev_t dn_q[$];
  int  multi_done = 0;

  always @(negedge clk) begin
    if (mul_start) iss_q.push_back(ev_t'{cyc, {NC{1'b0}}, mul_x, mul_y});
    if (done != '0) begin
      dn_q.push_back(ev_t'{cyc, done, o_o, {W{1'b0}}});
      if (!$onehot(done)) multi_done++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int c, input logic [W-1:0] xv, input logic [W-1:0] yv);
    x[W*c +: W] = xv;
    y[W*c +: W] = yv;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    start = '0;
    spur  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    iss_q.delete();
    dn_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_tests++; if (busy !== 3'b000) begin n_fail++; $display("FAIL reset_busy got %b want 000", busy); end
    n_tests++; if (done !== 3'b000 || o_o !== 32'h0) begin n_fail++; $display("FAIL reset_done got %b/%h want 000/0", done, o_o); end
    n_tests++; if (mul_start !== 1'b0 || mul_x !== 32'h0 || mul_y !== 32'h0) begin
      n_fail++; $display("FAIL reset_mul got %b/%h/%h want 0/0/0", mul_start, mul_x, mul_y);
    end
    n_tests++; if (err !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b want 00", err); end
  endtask

  task automatic test_single();
    apply_reset();
    lat_m1 = 4'd2;
    set_op(0, 32'h1, 32'h12345678);
    start = 3'b001;
    tick();
    start = '0;
    n_tests++; if (busy !== 3'b001) begin n_fail++; $display("FAIL single_busy got %b want 001", busy); end
    tick();
    n_tests++; if (mul_start !== 1'b1 || mul_y !== 32'h12345678) begin
      n_fail++; $display("FAIL single_issue got %b/%h want 1/12345678", mul_start, mul_y);
    end
    repeat (4) tick();
    n_tests++; if (done !== 3'b001 || o_o !== 32'h12345678) begin
      n_fail++; $display("FAIL single_done got %b/%h want 001/12345678", done, o_o);
    end
    tick();
    n_tests++; if (done !== 3'b000 || err !== 2'b00) begin
      n_fail++; $display("FAIL single_after got %b/%b want 000/00", done, err);
    end
  endtask

  task automatic test_contention();
    int c0;
    apply_reset();
    lat_m1 = 4'd2;
    set_op(0, 32'h1, 32'hAAAAAAAA);
    set_op(1, 32'h1, 32'h55555555);
    start = 3'b011;
    c0 = cyc;
    tick();
    start = '0;
    repeat (8) tick();
    n_tests++;
    if (iss_q.size() != 2 || iss_q[0].b !== 32'hAAAAAAAA || iss_q[0].cyc != c0 + 2 ||
        iss_q[1].b !== 32'h55555555 || iss_q[1].cyc != c0 + 3) begin
      n_fail++; $display("FAIL contention_issue got n=%0d want AAAAAAAA@%0d then 55555555@%0d",
                         iss_q.size(), c0 + 2, c0 + 3);
    end
    n_tests++;
    if (dn_q.size() != 2 || dn_q[0].who !== 3'b001 || dn_q[0].a !== 32'hAAAAAAAA ||
        dn_q[0].cyc != c0 + 6 || dn_q[1].who !== 3'b010 || dn_q[1].a !== 32'h55555555) begin
      n_fail++; $display("FAIL contention_done got n=%0d want 001:AAAAAAAA@%0d, 010:55555555",
                         dn_q.size(), c0 + 6);
    end
    // Client 0 alone, then a tie: client 1 must now win.
    iss_q.delete();
    dn_q.delete();
    start = 3'b001;
    tick();
    start = '0;
    tick();
    start = 3'b011;
    tick();
    start = '0;
    repeat (8) tick();
    n_tests++;
    if (iss_q.size() != 3 || iss_q[1].b !== 32'h55555555 || iss_q[2].b !== 32'hAAAAAAAA) begin
      n_fail++; $display("FAIL contention_rotate got n=%0d want solo0, 1, 0", iss_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    apply_reset();
    lat_m1 = 4'd7;
    c0 = cyc;
    for (int k = 0; k < 6; k++) begin
      set_op(0, 32'h1, 32'h100 + 32'(k));
      start = 3'b001;
      tick();
    end
    start = '0;
    n_tests++; if (err !== 2'b01) begin n_fail++; $display("FAIL bp_overrun got %b want 01", err); end
    tick();
    tick();
    n_tests++; if (busy[0] !== 1'b1 || mul_start !== 1'b0 || iss_q.size() != 4) begin
      n_fail++; $display("FAIL bp_stall got busy=%b start=%b n=%0d want 1/0/4", busy[0], mul_start,
                         iss_q.size());
    end
    repeat (17) tick();
    n_tests++;
    if (iss_q.size() != 5 || iss_q[3].cyc != c0 + 5 || iss_q[4].cyc != c0 + 11) begin
      n_fail++; $display("FAIL bp_issue_timing got n=%0d want 5 with 4th@%0d 5th@%0d", iss_q.size(),
                         c0 + 5, c0 + 11);
    end
    n_tests++;
    if (dn_q.size() != 5) begin
      n_fail++; $display("FAIL bp_done_count got %0d want 5", dn_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (dn_q[k].who !== 3'b001 || dn_q[k].a !== 32'h100 + 32'(k)) begin
          n_fail++; $display("FAIL bp_done_order[%0d] got %b/%h want 001/%h", k, dn_q[k].who,
                             dn_q[k].a, 32'h100 + 32'(k));
          break;
        end
      end
    end
  endtask

  task automatic test_spurious();
    apply_reset();
    spur_val = 32'hDEADBEEF;
    spur     = 1'b1;
    tick();
    spur     = 1'b0;
    n_tests++; if (err !== 2'b10 || done !== 3'b000) begin
      n_fail++; $display("FAIL spurious got err=%b done=%b want 10/000", err, done);
    end
    tick();
    n_tests++; if (dn_q.size() != 0) begin
      n_fail++; $display("FAIL spurious_nodone got %0d dones want 0", dn_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    lat_m1 = 4'd2;
    set_op(0, 32'h1, 32'h11);
    set_op(1, 32'h1, 32'h22);
    start = 3'b011;
    tick();
    start = '0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, o_o, mul_start, mul_x, mul_y, err} !== '0) begin
      n_fail++; $display("FAIL midrst_outputs got busy=%b done=%b start=%b x=%h y=%h err=%b want 0",
                         busy, done, mul_start, mul_x, mul_y, err);
    end
    tick();
    rst_n = 1'b1;
    iss_q.delete();
    dn_q.delete();
    // Tie of 1 and 2: with last_grant back at 2, client 1 wins.
    set_op(1, 32'h1, 32'h33);
    set_op(2, 32'h1, 32'h44);
    start = 3'b110;
    tick();
    start = '0;
    repeat (10) tick();
    n_tests++;
    if (iss_q.size() != 2 || iss_q[0].b !== 32'h33 || iss_q[1].b !== 32'h44) begin
      n_fail++; $display("FAIL midrst_issue got n=%0d want 33 then 44", iss_q.size());
    end
    n_tests++;
    if (dn_q.size() != 2 || dn_q[0].who !== 3'b010 || dn_q[0].a !== 32'h33 ||
        dn_q[1].who !== 3'b100 || dn_q[1].a !== 32'h44 || err !== 2'b00) begin
      n_fail++; $display("FAIL midrst_done got n=%0d err=%b want 010:33, 100:44, 00", dn_q.size(),
                         err);
    end
  endtask

  task automatic test_refill();
    int c0;
    apply_reset();
    lat_m1 = 4'd2;
    set_op(1, 32'h1, 32'h77);
    start = 3'b010;
    c0 = cyc;
    tick();
    set_op(1, 32'h1, 32'h88);
    tick();
    start = '0;
    n_tests++; if (busy !== 3'b010 || err !== 2'b00) begin
      n_fail++; $display("FAIL refill_accept got busy=%b err=%b want 010/00", busy, err);
    end
    repeat (8) tick();
    n_tests++;
    if (iss_q.size() != 2 || iss_q[0].b !== 32'h77 || iss_q[0].cyc != c0 + 2 ||
        iss_q[1].b !== 32'h88 || iss_q[1].cyc != c0 + 3) begin
      n_fail++; $display("FAIL refill_issue got n=%0d want 77@%0d 88@%0d", iss_q.size(), c0 + 2,
                         c0 + 3);
    end
    n_tests++;
    if (dn_q.size() != 2 || dn_q[1].who !== 3'b010 || dn_q[1].a !== 32'h88 || err !== 2'b00) begin
      n_fail++; $display("FAIL refill_done got n=%0d err=%b want 2 dones, 00", dn_q.size(), err);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] exp_q [NC][$];
    logic [W-1:0] xv, yv;
    int           h;
    int           bad;
    for (int run = 0; run < 2; run++) begin
      apply_reset();
      multi_done = 0;
      lat_m1 = 4'($urandom_range(0, 7));
      for (int c = 0; c < NC; c++) exp_q[c].delete();
      bad = 0;
      for (int t = 0; t < 440; t++) begin
        if (done != '0) begin
          h = 0;
          for (int c = 0; c < NC; c++) if (done[c]) h = c;
          if (exp_q[h].size() == 0) begin
            bad++; $display("FAIL rand_done client %0d got %h want none", h, o_o);
          end else begin
            if (o_o !== exp_q[h][0]) begin
              bad++; $display("FAIL rand_result client %0d got %h want %h", h, o_o, exp_q[h][0]);
            end
            void'(exp_q[h].pop_front());
          end
        end
        for (int c = 0; c < NC; c++) begin
          if (t < 400 && busy[c] == 1'b0 && ($urandom % 3) != 0) begin
            xv = $urandom;
            yv = $urandom;
            set_op(c, xv, yv);
            start[c] = 1'b1;
            exp_q[c].push_back(xv * yv);
          end else begin
            start[c] = 1'b0;
          end
        end
        tick();
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rand_results got %0d bad want 0", bad); end
      n_tests++;
      if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0 || err !== 2'b00 ||
          multi_done != 0) begin
        n_fail++; $display("FAIL rand_drain got left=%0d err=%b multi=%0d want 0/00/0",
                           exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), err, multi_done);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_spurious();
    test_reset_midflight();
    test_refill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
